// File: rtl/deser_arbiter.sv
// Round-robin arbiter that shares one DESER_W-bit deserializer among N_SRC serial lanes.
// Optional idle-bit timeout abort is enabled by defining DESER_ARB_TIMEOUT_EN.
module deser_arbiter #(
    parameter int N_SRC       = 4,
    parameter int DESER_W     = 16,
`ifdef DESER_ARB_TIMEOUT_EN
    parameter int TIMEOUT_CYC = 64,
`endif
    localparam int ID_W       = $clog2(N_SRC)
) (
    input  logic               clk_i,
    input  logic               srst_i,
    input  logic [N_SRC-1:0]   req_i,
    output logic [N_SRC-1:0]   gnt_o,
    input  logic [N_SRC-1:0]   data_i,
    input  logic [N_SRC-1:0]   data_val_i,
    output logic               deser_data_o,
    output logic               deser_data_val_o,
    output logic               deser_srst_o,
    input  logic [DESER_W-1:0] deser_ser_data_i,
    input  logic               deser_ser_data_val_i,
    output logic [DESER_W-1:0] word_o,
    output logic [ID_W-1:0]    word_id_o,
    output logic               word_val_o,
    output logic               busy_o
);

    localparam int CNT_W = $clog2(DESER_W + 1);

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_BUSY,
        ST_WAIT_OUT
    } state_e;

    state_e             state_q, state_d;
    logic [ID_W-1:0]    cur_id_q, cur_id_d;
    logic [ID_W-1:0]    last_q, last_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [N_SRC-1:0]   gnt_q, gnt_d;
    logic [DESER_W-1:0] word_q, word_d;
    logic [ID_W-1:0]    word_id_q, word_id_d;
    logic               word_val_q, word_val_d;
    logic               pick_found;
    logic [ID_W-1:0]    pick_id;
    logic               bit_val;

`ifdef DESER_ARB_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYC + 1);
    logic [IDLE_W-1:0]  idle_cnt_q, idle_cnt_d;
    logic               abort_q, abort_d;
`endif

    // Scan starts one past the last winner, so the previous winner is considered last.
    always_comb begin
        pick_found = 1'b0;
        pick_id    = '0;
        for (int i = 1; i <= N_SRC; i++) begin
            if (!pick_found && req_i[(int'(last_q) + i) % N_SRC]) begin
                pick_found = 1'b1;
                pick_id    = ID_W'((int'(last_q) + i) % N_SRC);
            end
        end
    end

    assign bit_val          = data_val_i[cur_id_q];
    assign deser_data_o     = (state_q == ST_BUSY) ? data_i[cur_id_q] : 1'b0;
    assign deser_data_val_o = (state_q == ST_BUSY) ? bit_val : 1'b0;
    assign gnt_o            = gnt_q;
    assign word_o           = word_q;
    assign word_id_o        = word_id_q;
    assign word_val_o       = word_val_q;
    assign busy_o           = (state_q != ST_IDLE);

`ifdef DESER_ARB_TIMEOUT_EN
    assign deser_srst_o = srst_i | abort_q;
`else
    assign deser_srst_o = srst_i;
`endif

    always_comb begin
        // NOTE: every *_d gets its hold value first so no path through the case infers a latch.
        state_d    = state_q;
        cur_id_d   = cur_id_q;
        last_d     = last_q;
        cnt_d      = cnt_q;
        gnt_d      = gnt_q;
        word_d     = word_q;
        word_id_d  = word_id_q;
        word_val_d = 1'b0;
`ifdef DESER_ARB_TIMEOUT_EN
        idle_cnt_d = idle_cnt_q;
        abort_d    = 1'b0;
`endif
        unique case (state_q)
            ST_IDLE: begin
                if (pick_found) begin
                    cur_id_d = pick_id;
                    last_d   = pick_id;
                    gnt_d    = N_SRC'(1) << pick_id;
                    cnt_d    = '0;
                    state_d  = ST_BUSY;
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                end
            end
            ST_BUSY: begin
                if (bit_val) begin
`ifdef DESER_ARB_TIMEOUT_EN
                    idle_cnt_d = '0;
`endif
                    if (cnt_q == CNT_W'(DESER_W - 1)) begin
                        cnt_d   = '0;
                        gnt_d   = '0;
                        state_d = ST_WAIT_OUT;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
`ifdef DESER_ARB_TIMEOUT_EN
                // A stalled lane aborts the word and flushes the deserializer's partial bits.
                else if (idle_cnt_q == IDLE_W'(TIMEOUT_CYC - 1)) begin
                    idle_cnt_d = '0;
                    cnt_d      = '0;
                    gnt_d      = '0;
                    abort_d    = 1'b1;
                    state_d    = ST_IDLE;
                end else begin
                    idle_cnt_d = idle_cnt_q + IDLE_W'(1);
                end
`endif
            end
            ST_WAIT_OUT: begin
                if (deser_ser_data_val_i) begin
                    word_d     = deser_ser_data_i;
                    word_id_d  = cur_id_q;
                    word_val_d = 1'b1;
                    state_d    = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            state_q    <= ST_IDLE;
            cur_id_q   <= '0;
            last_q     <= ID_W'(N_SRC - 1);
            cnt_q      <= '0;
            gnt_q      <= '0;
            word_q     <= '0;
            word_id_q  <= '0;
            word_val_q <= 1'b0;
`ifdef DESER_ARB_TIMEOUT_EN
            idle_cnt_q <= '0;
            abort_q    <= 1'b0;
`endif
        end else begin
            state_q    <= state_d;
            cur_id_q   <= cur_id_d;
            last_q     <= last_d;
            cnt_q      <= cnt_d;
            gnt_q      <= gnt_d;
            word_q     <= word_d;
            word_id_q  <= word_id_d;
            word_val_q <= word_val_d;
`ifdef DESER_ARB_TIMEOUT_EN
            idle_cnt_q <= idle_cnt_d;
            abort_q    <= abort_d;
`endif
        end
    end

endmodule

// File: tb/tb_deser_arbiter.sv
// Directed self-checking bench for deser_arbiter with a behavioural MSB-first deserializer.
// The timeout scenario runs only when DESER_ARB_TIMEOUT_EN is defined.
module tb_deser_arbiter;

    logic        clk;
    logic        srst;
    logic [3:0]  req;
    logic [3:0]  gnt;
    logic [3:0]  data;
    logic [3:0]  data_val;
    logic        deser_data;
    logic        deser_data_val;
    logic        deser_srst;
    logic [15:0] ser_data;
    logic        ser_val;
    logic [15:0] word;
    logic [1:0]  word_id;
    logic        word_val;
    logic        busy;

    int checks = 0;
    int errors = 0;
    int pulses = 0;
    int overlap = 0;

    deser_arbiter dut (
        .clk_i                (clk),
        .srst_i               (srst),
        .req_i                (req),
        .gnt_o                (gnt),
        .data_i               (data),
        .data_val_i           (data_val),
        .deser_data_o         (deser_data),
        .deser_data_val_o     (deser_data_val),
        .deser_srst_o         (deser_srst),
        .deser_ser_data_i     (ser_data),
        .deser_ser_data_val_i (ser_val),
        .word_o               (word),
        .word_id_o            (word_id),
        .word_val_o           (word_val),
        .busy_o               (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural deserializer: shifts MSB-first, presents the word one cycle after bit 16.
    logic [15:0] dsh;
    logic [4:0]  dcnt;
    always @(posedge clk) begin
        if (deser_srst) begin
            dsh      <= '0;
            dcnt     <= '0;
            ser_val  <= 1'b0;
            ser_data <= '0;
        end else begin
            ser_val <= 1'b0;
            if (deser_data_val) begin
                dsh <= {dsh[14:0], deser_data};
                if (dcnt == 5'd15) begin
                    dcnt     <= '0;
                    ser_val  <= 1'b1;
                    ser_data <= {dsh[14:0], deser_data};
                end else begin
                    dcnt <= dcnt + 5'd1;
                end
            end
        end
    end

    always @(negedge clk) begin
        if (word_val === 1'b1) pulses++;
        if (!$onehot0(gnt)) overlap++;
    end

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        srst     = 1'b1;
        req      = '0;
        data     = '0;
        data_val = '0;
        tick();
        tick();
        srst = 1'b0;
    endtask

    task automatic wait_gnt();
        for (int i = 0; i < 20; i++) begin
            tick();
            if (gnt != 4'b0000) break;
        end
    endtask

    task automatic wait_word();
        for (int i = 0; i < 10; i++) begin
            tick();
            if (word_val === 1'b1) break;
        end
    endtask

    task automatic send_bits(input int src, input logic [15:0] w, input int first,
                             input int last_bit, input int noise);
        for (int b = first; b <= last_bit; b++) begin
            data     = '0;
            data_val = '0;
            data[src]     = w[15-b];
            data_val[src] = 1'b1;
            if (noise >= 0) begin
                data[noise]     = b[0];
                data_val[noise] = ~b[0];
            end
            tick();
        end
        data     = '0;
        data_val = '0;
    endtask

    initial begin
        int p0;
        logic [15:0] w;

        // 1: reset values, single source, 0xA5C3
        srst = 1'b1; req = '0; data = '0; data_val = '0;
        tick();
        tick();
        check("rst_gnt", gnt, 4'b0000);
        check("rst_busy", busy, 1'b0);
        check("rst_word", word, 16'h0000);
        check("rst_id", word_id, 2'd0);
        check("rst_val", word_val, 1'b0);
        check("rst_deser_srst", deser_srst, 1'b1);
        srst = 1'b0;
        req = 4'b0001;
        wait_gnt();
        check("t1_gnt", gnt, 4'b0001);
        check("t1_busy", busy, 1'b1);
        req = 4'b0000;
        send_bits(0, 16'hA5C3, 0, 7, -1);
        check("t1_gnt_mid", gnt, 4'b0001);
        send_bits(0, 16'hA5C3, 8, 15, -1);
        check("t1_gnt_done", gnt, 4'b0000);
        data_val = 4'b0001;
        #1;
        check("t1_wait_val", deser_data_val, 1'b0);
        data_val = '0;
        p0 = pulses;
        wait_word();
        check("t1_word_val", word_val, 1'b1);
        check("t1_word", word, 16'hA5C3);
        check("t1_id", word_id, 2'd0);
        tick();
        check("t1_val_pulse", word_val, 1'b0);
        check("t1_pulses", pulses - p0, 1);

        // 2: all four requesting, round-robin 0,1,2,3,0
        do_reset();
        req = 4'b1111;
        for (int k = 0; k < 5; k++) begin
            w = 16'h1234 + 16'(k * 16'h1111);
            wait_gnt();
            check("t2_gnt", gnt, 32'(4'b0001 << (k % 4)));
            send_bits(k % 4, w, 0, 15, -1);
            wait_word();
            check("t2_id", word_id, 32'(k % 4));
            check("t2_word", word, w);
        end
        req = 4'b0000;
        tick();
        tick();
        check("t2_onehot", overlap, 0);

        // 3: src1 with a 3-cycle valid gap, src2 toggling throughout
        do_reset();
        req = 4'b0010;
        wait_gnt();
        check("t3_gnt", gnt, 4'b0010);
        req = 4'b0000;
        send_bits(1, 16'h3C5A, 0, 13, 2);
        for (int g = 0; g < 3; g++) begin
            data     = 4'b0100;
            data_val = 4'b0100;
            #1;
            check("t3_gap_val", deser_data_val, 1'b0);
            tick();
        end
        check("t3_gnt_hold", gnt, 4'b0010);
        send_bits(1, 16'h3C5A, 14, 15, 2);
        wait_word();
        check("t3_word", word, 16'h3C5A);
        check("t3_id", word_id, 2'd1);

        // 4: reset after 8 bits
        do_reset();
        req = 4'b0001;
        wait_gnt();
        req = 4'b0000;
        send_bits(0, 16'hFFFF, 0, 7, -1);
        srst = 1'b1;
        #1;
        check("t4_deser_srst", deser_srst, 1'b1);
        p0 = pulses;
        tick();
        check("t4_gnt", gnt, 4'b0000);
        check("t4_busy", busy, 1'b0);
        check("t4_val", word_val, 1'b0);
        srst = 1'b0;
        repeat (5) tick();
        check("t4_no_word", pulses - p0, 0);
        req = 4'b1111;
        wait_gnt();
        check("t4_src0_first", gnt, 4'b0001);
        req = 4'b0000;

`ifdef DESER_ARB_TIMEOUT_EN
        // 5: 5 bits then a 64-cycle stall aborts the word
        do_reset();
        req = 4'b0001;
        wait_gnt();
        check("t5_gnt", gnt, 4'b0001);
        req = 4'b0010;
        send_bits(0, 16'hF800, 0, 4, -1);
        p0 = pulses;
        repeat (63) tick();
        check("t5_gnt_hold", gnt, 4'b0001);
        tick();
        check("t5_gnt_drop", gnt, 4'b0000);
        check("t5_abort_srst", deser_srst, 1'b1);
        tick();
        check("t5_srst_pulse", deser_srst, 1'b0);
        check("t5_next_gnt", gnt, 4'b0010);
        check("t5_no_word", pulses - p0, 0);
        req = 4'b0000;
`endif

        // 6: src3 request arrives with src2's word_val pulse
        do_reset();
        req = 4'b0100;
        wait_gnt();
        check("t6_gnt", gnt, 4'b0100);
        req = 4'b0000;
        send_bits(2, 16'h00FF, 0, 15, -1);
        wait_word();
        check("t6_val", word_val, 1'b1);
        check("t6_id", word_id, 2'd2);
        check("t6_word", word, 16'h00FF);
        req = 4'b1000;
        tick();
        check("t6_gnt3", gnt, 4'b1000);
        req = 4'b0000;
        do_reset();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
